// File: rtl/mod_m_cascade_counter.sv
// mod_m_cascade_counter: D cascaded radix-M digits counting up or down, with
// synchronous clear/load, per-digit load clamping, wrap or saturate at the
// boundaries, a combinational terminal count and a registered overflow pulse.
module mod_m_cascade_counter #(
    parameter int M        = 10,
    parameter int N        = 4,
    parameter int D        = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clear,
    input  logic           load,
    input  logic [D*N-1:0] loadValue,
    input  logic           en,
    input  logic           up,
    output logic [D*N-1:0] count,
    output logic           tc,
    output logic           overflow
);

    // Largest legal digit value; fits in N bits because 2^N >= M.
    localparam logic [N-1:0] DMAX = N'(M - 1);

    // Reject parameter sets that cannot represent a digit.
    if (M < 2 || (2 ** N) < M || D < 1) begin : g_bad_params
        $error("mod_m_cascade_counter: need M >= 2, 2^N >= M, D >= 1");
    end

    // Digit views of the packed vectors; digit 0 is the least significant.
    logic [D-1:0][N-1:0] dig;
    logic [D-1:0][N-1:0] ldv;
    logic [D-1:0][N-1:0] ld_clamp;
    logic [D-1:0][N-1:0] cnt_next;
    logic                run_max;
    logic                run_min;
    logic                all_max;
    logic                all_min;
    logic                at_bound;

    assign dig = count;
    assign ldv = loadValue;

    // Clamp load digits and compute the one-cycle carry/borrow step.
    // run_max/run_min track "every lower digit is at M-1 / at 0", which is
    // exactly the enable for the current digit, so the whole chain resolves
    // combinationally in one pass.
    always_comb begin
        run_max  = 1'b1;
        run_min  = 1'b1;
        cnt_next = dig;
        ld_clamp = ldv;
        for (int k = 0; k < D; k++) begin
            ld_clamp[k] = (ldv[k] > DMAX) ? DMAX : ldv[k];
            if (up) begin
                if (run_max) cnt_next[k] = (dig[k] == DMAX) ? '0 : dig[k] + 1'b1;
            end else begin
                if (run_min) cnt_next[k] = (dig[k] == '0) ? DMAX : dig[k] - 1'b1;
            end
            run_max = run_max & (dig[k] == DMAX);
            run_min = run_min & (dig[k] == '0);
        end
        all_max = run_max;
        all_min = run_min;
    end

    assign at_bound = up ? all_max : all_min;

    // Terminal count is masked by any higher-priority action so it can feed
    // the enable of a following counter in the same cycle.
    assign tc = en & ~reset & ~clear & ~load & at_bound;

    // Count and overflow registers with reset > clear > load > en priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (load) begin
            count    <= ld_clamp;
            overflow <= 1'b0;
        end else if (en) begin
            // Saturate holds at the boundary; wrap falls out of the digit step.
            if (!(SATURATE && at_bound)) count <= cnt_next;
            overflow <= tc;
        end else begin
            overflow <= 1'b0;
        end
    end

endmodule
